// File: rtl/led_s2p_rx.sv
// Board-side receiver for the LED shift-register link: oversamples s_clk/s_din/s_clrn/s_pen,
// shifts DATA_BITS bits per frame and latches the frame to par_out on a rising parallel-enable.
module led_s2p_rx #(
    parameter int DATA_BITS       = 16,
    parameter int DATA_COUNT_BITS = 4,
    parameter bit INVERT          = 1'b1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 s_clk,
    input  logic                 s_din,
    input  logic                 s_clrn,
    input  logic                 s_pen,
    output logic [DATA_BITS-1:0] par_out,
    output logic                 par_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [7:0]           frame_cnt,
    output logic [1:0]           dbg_state
);

    localparam int CNT_W = DATA_COUNT_BITS + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_BITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    // Two-flop synchronisers; clk and pen keep a third flop for edge detection.
    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_din_s1, r_din_s2;
    logic r_clrn_s1, r_clrn_s2;
    logic r_pen_s1, r_pen_s2, r_pen_prev;

    logic [DATA_BITS-1:0] r_sr;
    logic [CNT_W-1:0]     r_cnt;
    logic [1:0]           r_state;
    logic [DATA_BITS-1:0] r_par_out;
    logic                 r_par_valid;
    logic                 r_frame_err;
    logic                 r_busy;
    logic [7:0]           r_frame_cnt;

    logic                 w_clk_rise;
    logic                 w_pen_rise;
    logic                 w_good;
    logic                 w_bad;
    logic [DATA_BITS-1:0] w_sr_nxt;
    logic [DATA_BITS-1:0] w_sr_shift;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic [1:0]           w_state_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_clk_s1   <= 1'b0;
            r_clk_s2   <= 1'b0;
            r_clk_prev <= 1'b0;
            r_din_s1   <= 1'b0;
            r_din_s2   <= 1'b0;
            r_clrn_s1  <= 1'b0;
            r_clrn_s2  <= 1'b0;
            r_pen_s1   <= 1'b0;
            r_pen_s2   <= 1'b0;
            r_pen_prev <= 1'b0;
        end else begin
            r_clk_s1   <= s_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_din_s1   <= s_din;
            r_din_s2   <= r_din_s1;
            r_clrn_s1  <= s_clrn;
            r_clrn_s2  <= r_clrn_s1;
            r_pen_s1   <= s_pen;
            r_pen_s2   <= r_pen_s1;
            r_pen_prev <= r_pen_s2;
        end
    end

    assign w_clk_rise = r_clk_s2 & ~r_clk_prev;
    assign w_pen_rise = r_pen_s2 & ~r_pen_prev;
    assign w_sr_shift = {r_sr[DATA_BITS-2:0], r_din_s2};
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // Priority: clear > parallel-enable > shift clock. A shift edge coincident
    // with PEN is dropped, so PEN judges the count before that edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sr_nxt    = r_sr;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        if (!r_clrn_s2) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_sr_nxt    = '0;
        end else if (w_pen_rise) begin
            if ((r_state == ST_FULL) && (r_cnt == FULL_CNT)) begin
                w_good = 1'b1;
            end else begin
                w_bad = 1'b1;
            end
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_sr_nxt    = '0;
        end else if (w_clk_rise) begin
            case (r_state)
                ST_IDLE: begin
                    w_sr_nxt    = w_sr_shift;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = ST_SHIFT;
                end
                ST_SHIFT: begin
                    w_sr_nxt  = w_sr_shift;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == FULL_CNT) begin
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    w_state_nxt = ST_OVER;
                end
                default: begin
                    w_state_nxt = ST_OVER;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_sr        <= '0;
            r_busy      <= 1'b0;
            r_par_out   <= '0;
            r_par_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sr        <= w_sr_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_par_valid <= w_good;
            if (w_good) begin
                r_par_out   <= INVERT ? ~r_sr : r_sr;
                r_frame_err <= 1'b0;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end else if (w_bad) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    // par_valid is a one-cycle strobe with no ready: par_out/frame_cnt are valid on that cycle and held after.
    assign par_out   = r_par_out;
    assign par_valid = r_par_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;
    assign frame_cnt = r_frame_cnt;
    assign dbg_state = r_state;

endmodule
